ysyx_25030093_rf_wb_arb: RTL and testbench

Write-port arbiter for the CPU's integer register file. The register file has exactly one write port (wen/waddr/wdata). Two writeback sources compete for it: the execute unit (EXU: ALU/CSR results) and the load/store unit (LSU: load data). This block grants one source per cycle with a valid/ready handshake, bounds EXU starvation with a counter, drops x0 writes, and drives the register file's write port from a registered output stage.

---
 rtl/ysyx_25030093_rf_wb_arb.sv | 76 +++++++
 tb/tb_ysyx_25030093_rf_wb_arb.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_rf_wb_arb.sv
// Register-file write-port arbiter: grants EXU or LSU writebacks one per cycle,
// bounds EXU starvation, drops x0 writes and drives a registered write port.
module ysyx_25030093_rf_wb_arb #(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_waddr,
    input  logic [DATA_WIDTH-1:0] exu_wdata,

    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,

    output logic [3:0]            starve_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic                  exu_win;
    logic                  lsu_win;
    logic                  starved;
    logic [ADDR_WIDTH-1:0] win_waddr;
    logic [DATA_WIDTH-1:0] win_wdata;

    // LSU is preferred on a collision because late load data stalls the
    // pipeline longer; EXU only overrides once it has lost LIMIT times in a row.
    always_comb begin
        starved   = (starve_cnt == LIMIT);
        exu_win   = exu_valid && (!lsu_valid || starved);
        lsu_win   = lsu_valid && !exu_win;
        exu_ready = rst_n && exu_win;
        lsu_ready = rst_n && lsu_win;
        win_waddr = exu_win ? exu_waddr : lsu_waddr;
        win_wdata = exu_win ? exu_wdata : lsu_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (exu_win) begin
            starve_cnt <= '0;
        end else if (exu_valid && !starved) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // A granted x0 write still completes its handshake but never raises rf_wen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            rf_wen <= 1'b0;
            if (exu_win || lsu_win) begin
                rf_wen   <= (win_waddr != '0);
                rf_waddr <= win_waddr;
                rf_wdata <= win_wdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_rf_wb_arb.sv
// Directed bench for the register-file writeback arbiter; a negedge monitor
// compares every rf write against a queue of expected writes.
module tb_ysyx_25030093_rf_wb_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        exu_valid, lsu_valid;
    logic        exu_ready, lsu_ready;
    logic [4:0]  exu_waddr, lsu_waddr, rf_waddr;
    logic [31:0] exu_wdata, lsu_wdata, rf_wdata;
    logic        rf_wen;
    logic [3:0]  starve_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [36:0] exp_q[$];

    ysyx_25030093_rf_wb_arb #(
        .ADDR_WIDTH  (5),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_waddr (exu_waddr),
        .exu_wdata (exu_wdata),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_waddr (lsu_waddr),
        .lsu_wdata (lsu_wdata),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rf write must match the oldest outstanding expectation.
    initial begin
        logic [36:0] exp_w;
        forever begin
            @(negedge clk);
            if (rf_wen === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {27'd0, rf_waddr, rf_wdata}, 64'd0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("write_addr", {59'd0, rf_waddr}, {59'd0, exp_w[36:32]});
                    check("write_data", {32'd0, rf_wdata}, {32'd0, exp_w[31:0]});
                end
            end
        end
    end

    // One cycle of stimulus; er/lr/cnt/wen are the hand-derived values expected
    // during this cycle (wen reflects the transfer at the previous edge).
    task automatic step(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic er, input logic lr, input logic [3:0] cnt,
                        input logic wen);
        @(posedge clk);
        #1;
        exu_valid = ev; exu_waddr = ea; exu_wdata = ed;
        lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
        if (er && ea != 5'd0) exp_q.push_back({ea, ed});
        if (lr && la != 5'd0) exp_q.push_back({la, ld});
        @(negedge clk);
        check("exu_ready",  {63'd0, exu_ready},  {63'd0, er});
        check("lsu_ready",  {63'd0, lsu_ready},  {63'd0, lr});
        check("starve_cnt", {60'd0, starve_cnt}, {60'd0, cnt});
        check("rf_wen",     {63'd0, rf_wen},     {63'd0, wen});
    endtask

    task automatic idle(input logic [3:0] cnt, input logic wen);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, cnt, wen);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        exu_valid = 1'b1; exu_waddr = 5'd1; exu_wdata = 32'h1;
        lsu_valid = 1'b1; lsu_waddr = 5'd2; lsu_wdata = 32'h2;
        #12;
        check("reset_exu_ready", {63'd0, exu_ready}, 64'd0);
        check("reset_lsu_ready", {63'd0, lsu_ready}, 64'd0);
        check("reset_rf_wen",    {63'd0, rf_wen},    64'd0);
        @(posedge clk);
        #1;
        exu_valid = 1'b0; lsu_valid = 1'b0;
        rst_n = 1'b1;

        // Single source
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0);
        idle(4'd0, 1'b1);
        idle(4'd0, 1'b0);

        // Collision on x3: LSU first, EXU value lands last
        step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0, 1'b1, 4'd0, 1'b0);
        step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd1, 1'b1);
        idle(4'd0, 1'b1);
        idle(4'd0, 1'b0);

        // Starvation: four LSU wins, then forced EXU win
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hA0, 1'b0, 1'b1, 4'd0, 1'b0);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd11, 32'hA1, 1'b0, 1'b1, 4'd1, 1'b1);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd12, 32'hA2, 1'b0, 1'b1, 4'd2, 1'b1);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd13, 32'hA3, 1'b0, 1'b1, 4'd3, 1'b1);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd14, 32'hA4, 1'b1, 1'b0, 4'd4, 1'b1);
        step(1'b0, 5'd0, 32'd0,  1'b1, 5'd14, 32'hA4, 1'b0, 1'b1, 4'd0, 1'b1);
        idle(4'd0, 1'b1);
        idle(4'd0, 1'b0);

        // x0 drop: handshake completes, no write
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 4'd0, 1'b0);
        idle(4'd0, 1'b0);

        // Throughput: alternating sources, one write per cycle
        step(1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 32'd0,   1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b0, 5'd0, 32'd0,   1'b1, 5'd2, 32'h202, 1'b0, 1'b1, 4'd0, 1'b1);
        step(1'b1, 5'd3, 32'h303, 1'b0, 5'd0, 32'd0,   1'b1, 1'b0, 4'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0,   1'b1, 5'd4, 32'h404, 1'b0, 1'b1, 4'd0, 1'b1);
        step(1'b1, 5'd5, 32'h505, 1'b0, 5'd0, 32'd0,   1'b1, 1'b0, 4'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0,   1'b1, 5'd6, 32'h606, 1'b0, 1'b1, 4'd0, 1'b1);
        step(1'b1, 5'd7, 32'h707, 1'b0, 5'd0, 32'd0,   1'b1, 1'b0, 4'd0, 1'b1);
        step(1'b0, 5'd0, 32'd0,   1'b1, 5'd8, 32'h808, 1'b0, 1'b1, 4'd0, 1'b1);
        idle(4'd0, 1'b1);
        idle(4'd0, 1'b0);

        // Reset mid-burst with both sources requesting
        step(1'b1, 5'd15, 32'hE, 1'b1, 5'd16, 32'hF, 1'b0, 1'b1, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        lsu_waddr = 5'd17; lsu_wdata = 32'h10;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_rf_wen",     {63'd0, rf_wen},     64'd0);
        check("midreset_rf_waddr",   {59'd0, rf_waddr},   64'd0);
        check("midreset_rf_wdata",   {32'd0, rf_wdata},   64'd0);
        check("midreset_starve_cnt", {60'd0, starve_cnt}, 64'd0);
        check("midreset_exu_ready",  {63'd0, exu_ready},  64'd0);
        check("midreset_lsu_ready",  {63'd0, lsu_ready},  64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back({5'd17, 32'h10});
        @(negedge clk);
        check("postreset_exu_ready",  {63'd0, exu_ready},  64'd0);
        check("postreset_lsu_ready",  {63'd0, lsu_ready},  64'd1);
        check("postreset_starve_cnt", {60'd0, starve_cnt}, 64'd0);
        step(1'b1, 5'd15, 32'hE, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 4'd1, 1'b1);
        idle(4'd0, 1'b1);
        idle(4'd0, 1'b0);

        check("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
